// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO stream reader.
//   rd_state_t      : reader control states
//   OBUF_DEPTH_DFLT : default output buffer depth
//   OBUF_AW         : pointer width for the default buffer depth
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    localparam int OBUF_DEPTH_DFLT = 4;
    localparam int OBUF_AW         = $clog2(OBUF_DEPTH_DFLT);

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small circular register buffer holding words returned by the FIFO.
//   clk, rst  : clock, synchronous active-high reset (also zeroes storage)
//   clear     : drop all entries (pointers and occupancy to zero)
//   push/wdata: append one word
//   pop       : remove the head word (caller guarantees occupancy != 0)
//   head      : word at the read pointer
//   occupancy : number of stored words, 0..DEPTH
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = OBUF_DEPTH_DFLT,
    parameter int AW         = OBUF_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [AW:0]           occupancy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Head is read straight from the registers so it stays stable while stalled.
    assign head = mem[rptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a FIFO with fixed read latency. Issues reads only when
// the output buffer has room for every word already in flight, and presents
// the returned words as a bubble-free valid/ready stream.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : allow new FIFO reads
//   flush               : discard buffered words and drain the FIFO
//   ff_empty, ff_rdata  : FIFO status and read data
//   ff_ren              : FIFO read enable
//   m_valid/m_data/m_ready : output stream
//   busy                : not idle, or words in flight / buffered
//   flush_done          : one-cycle pulse after a flush finishes
//   word_count          : delivered words, wrapping
//
// state | meaning
// IDLE  | no reads issued, nothing in flight or buffered
// RUN   | reads issued under buffer credit, words delivered downstream
// FLUSH | output blocked, FIFO read until empty, returned data dropped
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DFLT,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  ff_empty,
    input  logic [DATA_WIDTH-1:0] ff_rdata,
    output logic                  ff_ren,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int AW = $clog2(OBUF_DEPTH);
    localparam int IW = $clog2(RD_LATENCY + 1);

    rd_state_t             state;
    rd_state_t             state_next;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [IW-1:0]         inflight;
    logic [AW:0]           occupancy;
    logic                  accept;
    logic                  land;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic                  obuf_clear;
    logic                  flush_done_next;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IW'(vld_pipe[i]);
        end
    end

    assign m_valid = (state != FLUSH) && (occupancy != '0);
    assign pop     = m_valid && m_ready;
    assign land    = vld_pipe[RD_LATENCY-1];
    // Words landing while flushing are dropped; the clear on flush entry
    // also overrides a push in that same cycle.
    assign push    = land && (state != FLUSH);
    assign accept  = ff_ren && !ff_empty;
    assign busy    = (state != IDLE) || (inflight != '0) || (occupancy != '0);

    // Every accepted read must have a buffer slot waiting for it, counting the
    // slot freed by a pop happening this very cycle.
    assign credit_ok = (int'(inflight) + int'(occupancy) - int'(pop)) < OBUF_DEPTH;

    always_comb begin
        state_next      = state;
        ff_ren          = 1'b0;
        obuf_clear      = 1'b0;
        flush_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_next = FLUSH;
                    obuf_clear = 1'b1;
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ff_ren = enable && !ff_empty && credit_ok;
                if (flush) begin
                    state_next = FLUSH;
                    obuf_clear = 1'b1;
                end else if (!enable && inflight == '0 && occupancy == '0) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                ff_ren = !ff_empty;
                if (ff_empty && inflight == '0) begin
                    state_next      = IDLE;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vld_pipe   <= '0;
            flush_done <= 1'b0;
            word_count <= '0;
        end else begin
            state       <= state_next;
            vld_pipe[0] <= accept;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            flush_done <= flush_done_next;
            if (pop) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

    fifo_rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OBUF_DEPTH),
        .AW         (AW)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (obuf_clear),
        .push      (push),
        .wdata     (ff_rdata),
        .pop       (pop),
        .head      (m_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based FIFO model drives
// the read port, and a transaction-level reference model predicts every
// output each cycle. Directed scenarios are followed by a randomized run.
module tb_fifo_stream_reader;

    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          ff_empty;
    logic [DW-1:0] ff_rdata;
    logic          ff_ren;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          flush_done;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .OBUF_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .ff_empty   (ff_empty),
        .ff_rdata   (ff_rdata),
        .ff_ren     (ff_ren),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .flush_done (flush_done),
        .word_count (word_count)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    // FIFO model: stored words and read data scheduled to appear on ff_rdata.
    logic [DW-1:0] fifo_q[$];
    ret_t          ret_q[$];

    // Reference model: mode 0 idle, 1 running, 2 flushing.
    int            m_mode;
    logic [DW-1:0] m_buf[$];
    int            m_fly[$];
    logic [CW-1:0] m_wc;
    bit            m_fd;

    int            cyc;
    int            n_checks;
    int            n_fail;
    logic [DW-1:0] del_q[$];
    int            first_acc;
    int            first_mv;
    int            mv_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_buf.delete();
        m_fly.delete();
        m_wc = '0;
        m_fd = 1'b0;
    endtask

    // One clock cycle, entered at a negedge with rst/enable/flush/m_ready set.
    // A read accepted in cycle c returns data during cycle c+LAT, which the
    // reader stores at the end of that cycle.
    task automatic cycle();
        int            infl;
        int            occ;
        int            prev_mode;
        bit            mv;
        bit            pop_e;
        bit            ren_e;
        bit            busy_e;
        bit            land;
        logic [DW-1:0] drv;
        ret_t          r;

        ff_empty = (fifo_q.size() == 0);
        drv = $urandom;
        if (ret_q.size() != 0 && ret_q[0].due == cyc) drv = ret_q[0].data;
        ff_rdata = drv;
        #1;

        infl  = m_fly.size();
        occ   = m_buf.size();
        mv    = (m_mode != 2) && (occ != 0);
        pop_e = mv && m_ready;
        case (m_mode)
            1:       ren_e = enable && !ff_empty && ((infl + occ - int'(pop_e)) < DEPTH);
            2:       ren_e = !ff_empty;
            default: ren_e = 1'b0;
        endcase
        busy_e = (m_mode != 0) || (infl != 0) || (occ != 0);

        chk("ff_ren", 64'(ff_ren), 64'(ren_e));
        chk("m_valid", 64'(m_valid), 64'(mv));
        chk("busy", 64'(busy), 64'(busy_e));
        chk("flush_done", 64'(flush_done), 64'(m_fd));
        chk("word_count", 64'(word_count), 64'(m_wc));
        if (mv) chk("m_data", 64'(m_data), 64'(m_buf[0]));

        if (m_valid === 1'b1 && m_ready) del_q.push_back(m_data);
        if (m_valid === 1'b1) mv_cycles++;
        if (first_acc < 0 && ff_ren === 1'b1 && !ff_empty) first_acc = cyc;
        if (first_mv < 0 && m_valid === 1'b1) first_mv = cyc;

        if (ret_q.size() != 0 && ret_q[0].due == cyc) void'(ret_q.pop_front());
        if (ff_ren === 1'b1 && !ff_empty) begin
            r.due  = cyc + LAT;
            r.data = fifo_q.pop_front();
            ret_q.push_back(r);
        end

        if (rst) begin
            model_reset();
        end else begin
            prev_mode = m_mode;
            land = (m_fly.size() != 0) && (m_fly[0] == cyc);
            if (land) void'(m_fly.pop_front());
            if (pop_e) begin
                void'(m_buf.pop_front());
                m_wc++;
            end
            if (land && m_mode != 2) m_buf.push_back(drv);
            if (ren_e && !ff_empty) m_fly.push_back(cyc + LAT);
            m_fd = 1'b0;
            case (m_mode)
                0: begin
                    if (flush) m_mode = 2;
                    else if (enable) m_mode = 1;
                end
                1: begin
                    if (flush) m_mode = 2;
                    else if (!enable && infl == 0 && occ == 0) m_mode = 0;
                end
                default: begin
                    if (ff_empty && infl == 0) begin
                        m_mode = 0;
                        m_fd   = 1'b1;
                    end
                end
            endcase
            if (m_mode == 2 && prev_mode != 2) m_buf.delete();
        end

        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_cnt;
        int mvc;
        logic [CW-1:0] wc0;

        rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        ff_empty = 1'b1; ff_rdata = '0;
        cyc = 0; n_checks = 0; n_fail = 0;
        first_acc = -1; first_mv = -1; mv_cycles = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        chk("reset_ff_ren", 64'(ff_ren), 64'd0);
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_m_data", 64'(m_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_flush_done", 64'(flush_done), 64'd0);
        chk("reset_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h10 + i);
        enable = 1'b1; m_ready = 1'b1;
        del_q.delete(); first_acc = -1; first_mv = -1;
        for (int i = 0; i < 40 && del_q.size() < 8; i++) cycle();
        chk("t1_count", 64'(del_q.size()), 64'd8);
        for (int i = 0; i < del_q.size(); i++) chk("t1_data", 64'(del_q[i]), 64'(32'h10 + i));
        // Accept edge closes cycle first_acc; m_valid rises LAT edges later.
        chk("t1_latency", 64'(first_mv - first_acc), 64'(LAT + 1));
        chk("t1_word_count", 64'(word_count), 64'd8);
        enable = 1'b0;
        repeat (4) cycle();
        chk("t1_busy_low", 64'(busy), 64'd0);

        // Backpressure with 0x11 at the head.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h10 + i);
        enable = 1'b1; m_ready = 1'b1;
        del_q.delete();
        for (int i = 0; i < 40 && del_q.size() < 1; i++) cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 64'(m_valid), 64'd1);
            chk("t2_hold_data", 64'(m_data), 64'h11);
            cycle();
        end
        chk("t2_ren_stopped", 64'(ff_ren), 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && del_q.size() < 8; i++) cycle();
        chk("t2_count", 64'(del_q.size()), 64'd8);
        for (int i = 0; i < del_q.size(); i++) chk("t2_data", 64'(del_q[i]), 64'(32'h10 + i));
        enable = 1'b0;
        repeat (4) cycle();

        // FIFO runs dry mid-stream.
        del_q.delete(); mv_cycles = 0;
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h30 + i);
        repeat (7) cycle();
        fifo_q.push_back(32'h33); fifo_q.push_back(32'h34);
        repeat (12) cycle();
        chk("t3_count", 64'(del_q.size()), 64'd5);
        for (int i = 0; i < del_q.size(); i++) chk("t3_data", 64'(del_q[i]), 64'(32'h30 + i));
        chk("t3_valid_cycles", 64'(mv_cycles), 64'd5);
        enable = 1'b0;
        repeat (4) cycle();

        // enable dropped with two reads in flight.
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'h40 + i);
        del_q.delete();
        enable = 1'b1; m_ready = 1'b1;
        repeat (3) cycle();
        enable = 1'b0;
        repeat (8) cycle();
        chk("t4_count", 64'(del_q.size()), 64'd2);
        if (del_q.size() == 2) begin
            chk("t4_data0", 64'(del_q[0]), 64'h40);
            chk("t4_data1", 64'(del_q[1]), 64'h41);
        end
        chk("t4_fifo_left", 64'(fifo_q.size()), 64'd4);
        chk("t4_busy_low", 64'(busy), 64'd0);
        fifo_q.delete();

        // Flush with 10 words in the FIFO and 3 buffered.
        for (int i = 0; i < 14; i++) fifo_q.push_back(32'h50 + i);
        enable = 1'b1; m_ready = 1'b0;
        repeat (6) cycle();
        wc0 = word_count;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_valid_dropped", 64'(m_valid), 64'd0);
        fd_cnt = 0; mvc = 0;
        for (int i = 0; i < 40; i++) begin
            if (flush_done === 1'b1) fd_cnt++;
            if (m_valid === 1'b1) mvc++;
            cycle();
        end
        chk("t5_done_pulses", 64'(fd_cnt), 64'd1);
        chk("t5_fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("t5_word_count", 64'(word_count), 64'(wc0));
        chk("t5_no_valid", 64'(mvc), 64'd0);
        enable = 1'b0;
        repeat (4) cycle();

        // Reset with two in flight and two buffered.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h60 + i);
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; enable = 1'b0; m_ready = 1'b1;
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_m_data", 64'(m_data), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_word_count", 64'(word_count), 64'd0);
        mvc = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_valid === 1'b1) mvc++;
            cycle();
        end
        chk("t6_no_valid", 64'(mvc), 64'd0);
        fifo_q.delete();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2500; i++) begin
            enable  = ($urandom_range(0, 9) < 8);
            m_ready = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
            cycle();
        end
        rst = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
